// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch display slice.
//  - SEG_* : active-low {g,f,e,d,c,b,a} patterns for decimal digits and blank
//  - DIG_* : scan index of each display digit (0 = rightmost)
//  - conv_state_t : states of the binary-to-BCD conversion sequencer
//  - seg_encode : BCD nibble to segment pattern, blank for non-decimal codes
package stopwatch_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [1:0] DIG_SEC_ONES = 2'd0;
    localparam logic [1:0] DIG_SEC_TENS = 2'd1;
    localparam logic [1:0] DIG_MIN_ONES = 2'd2;
    localparam logic [1:0] DIG_MIN_TENS = 2'd3;

    typedef enum logic [1:0] {
        CV_IDLE,
        CV_LOAD,
        CV_SHIFT,
        CV_DONE
    } conv_state_t;

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/stopwatch_display_if.sv
// Bundle between the stopwatch counter / board pins and the display driver.
//  min, sec : binary time from the counter (0-63)
//  adj, sel : adjust mode and selected field (0 = minutes, 1 = seconds)
//  seg, an, dp : active-low segment cathodes, digit anodes and decimal point
// master = counter/board side, slave = display driver.
interface stopwatch_display_if;
    logic [5:0] min;
    logic [5:0] sec;
    logic       adj;
    logic       sel;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    modport master (output min, sec, adj, sel, input seg, an, dp);
    modport slave  (input min, sec, adj, sel, output seg, an, dp);
endinterface

// File: rtl/stopwatch_display_bin2bcd6.sv
// Sequential 6-bit double-dabble converter.
//  clk, rst_n : clock, async active-low reset
//  start_i    : load bin_i and begin conversion (6 shift cycles)
//  busy_o     : conversion in progress
//  done_o     : one-cycle pulse, tens_o/ones_o valid from then until next start
module bin2bcd6_seq
    import stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic [5:0] bin_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o
);

    logic [5:0] bin_q, bin_d;
    logic [7:0] bcd_q, bcd_d;
    logic [2:0] cnt_q;
    logic       busy_q, done_q;
    logic [3:0] tens_adj, ones_adj;

    always_comb begin
        tens_adj = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
        ones_adj = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
        {bcd_d, bin_d} = {tens_adj, ones_adj, bin_q} << 1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                bin_q  <= bin_i;
                bcd_q  <= '0;
                cnt_q  <= 3'd6;
                busy_q <= 1'b1;
            end else if (busy_q) begin
                bin_q <= bin_d;
                bcd_q <= bcd_d;
                cnt_q <= cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign tens_o = bcd_q[7:4];
    assign ones_o = bcd_q[3:0];

endmodule

// File: rtl/stopwatch_display.sv
// Multiplexed MM.SS 7-segment driver for the stopwatch.
//  clk, rst_n : master clock, async active-low reset
//  disp       : slave side of stopwatch_display_if (min/sec/adj/sel in, seg/an/dp out)
// Binary inputs are converted once per frame, committed to the shown digits only at
// the frame boundary (no tearing), and the adjusted field blinks while adj=1.
//
//  state    | meaning
//  CV_IDLE  | waiting for idx to reach 3
//  CV_LOAD  | converters have snapshotted min/sec
//  CV_SHIFT | double-dabble running
//  CV_DONE  | pending BCD digits updated
module stopwatch_display
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int REFRESH_HZ = 1000,
    parameter int BLINK_HZ   = 2
) (
    input logic clk,
    input logic rst_n,
    stopwatch_display_if.slave disp
);

    localparam int DIGIT_CYC = CLK_HZ / (REFRESH_HZ * 4);
    localparam int BLINK_CYC = CLK_HZ / (2 * BLINK_HZ);
    localparam int RW        = $clog2(DIGIT_CYC + 1);
    localparam int BW        = $clog2(BLINK_CYC + 1);

    logic [RW-1:0] refresh_q, refresh_d;
    logic [1:0]    idx_q, idx_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          phase_q, phase_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    shown_q [4];
    logic [3:0]    pend_q  [4];
    conv_state_t   state_q;

    logic          scan_wrap, commit, start, field_sel;
    logic          min_busy, min_done, sec_busy, sec_done;
    logic [3:0]    min_tens, min_ones, sec_tens, sec_ones;

    always_comb begin
        scan_wrap = (refresh_q == RW'(DIGIT_CYC - 1));
        refresh_d = scan_wrap ? '0 : refresh_q + RW'(1);
        idx_d     = scan_wrap ? idx_q + 2'd1 : idx_q;
        commit    = scan_wrap && (idx_q == DIG_MIN_TENS);
        start     = (state_q == CV_IDLE) && scan_wrap && (idx_q == DIG_MIN_ONES);

        // Blink timebase only runs in adjust mode; leaving adjust clears it.
        blink_d = '0;
        phase_d = 1'b0;
        if (disp.adj) begin
            if (blink_q == BW'(BLINK_CYC - 1)) begin
                phase_d = ~phase_q;
            end else begin
                blink_d = blink_q + BW'(1);
                phase_d = phase_q;
            end
        end

        field_sel = disp.sel ? (idx_q == DIG_SEC_ONES || idx_q == DIG_SEC_TENS)
                             : (idx_q == DIG_MIN_ONES || idx_q == DIG_MIN_TENS);
        // adj gates the blank directly so digits reappear the cycle adj drops.
        an_d  = (disp.adj && phase_q && field_sel) ? 4'b1111 : ~(4'b0001 << idx_q);
        seg_d = seg_encode(shown_q[idx_q]);
        dp_d  = (idx_q != DIG_MIN_ONES);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_q <= '0;
            idx_q     <= '0;
            blink_q   <= '0;
            phase_q   <= 1'b0;
            an_q      <= 4'b1111;
            seg_q     <= SEG_BLANK;
            dp_q      <= 1'b1;
            for (int i = 0; i < 4; i++) shown_q[i] <= '0;
        end else begin
            refresh_q <= refresh_d;
            idx_q     <= idx_d;
            blink_q   <= blink_d;
            phase_q   <= phase_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            if (commit) shown_q <= pend_q;
        end
    end

    // Results are captured on the edge entering DONE so they are in place before
    // the idx 3->0 commit even at the minimum of 8 cycles per digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CV_IDLE;
            for (int i = 0; i < 4; i++) pend_q[i] <= '0;
        end else begin
            case (state_q)
                CV_IDLE:  if (start) state_q <= CV_LOAD;
                CV_LOAD:  if (min_busy && sec_busy) state_q <= CV_SHIFT;
                CV_SHIFT: begin
                    if (min_done && sec_done) begin
                        state_q              <= CV_DONE;
                        pend_q[DIG_SEC_ONES] <= sec_ones;
                        pend_q[DIG_SEC_TENS] <= sec_tens;
                        pend_q[DIG_MIN_ONES] <= min_ones;
                        pend_q[DIG_MIN_TENS] <= min_tens;
                    end
                end
                CV_DONE:  state_q <= CV_IDLE;
                default:  state_q <= CV_IDLE;
            endcase
        end
    end

    bin2bcd6_seq u_bcd_min (
        .clk    (clk),
        .rst_n  (rst_n),
        .start_i(start),
        .bin_i  (disp.min),
        .busy_o (min_busy),
        .done_o (min_done),
        .tens_o (min_tens),
        .ones_o (min_ones)
    );

    bin2bcd6_seq u_bcd_sec (
        .clk    (clk),
        .rst_n  (rst_n),
        .start_i(start),
        .bin_i  (disp.sec),
        .busy_o (sec_busy),
        .done_o (sec_done),
        .tens_o (sec_tens),
        .ones_o (sec_ones)
    );

    assign disp.an  = an_q;
    assign disp.seg = seg_q;
    assign disp.dp  = dp_q;

endmodule

// File: tb/tb_stopwatch_display.sv
// Bench for stopwatch_display: a cycle-count reference model pushes the expected
// display output for every clock into a queue; a monitor pops and compares it.
module tb_stopwatch_display;

    localparam int CLK_HZ     = 1600;
    localparam int REFRESH_HZ = 50;
    localparam int BLINK_HZ   = 10;
    localparam int DIG        = 8;
    localparam int FRAME      = 4 * DIG;
    localparam int BLINK      = 80;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    stopwatch_display_if disp ();

    stopwatch_display #(
        .CLK_HZ    (CLK_HZ),
        .REFRESH_HZ(REFRESH_HZ),
        .BLINK_HZ  (BLINK_HZ)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .disp (disp)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    exp_t exp_q [$];
    int checks = 0;
    int errors = 0;

    // Reference model: n = clock edges since reset release. Digit k of frame f is
    // shown during edges 32f+8k+1 .. 32f+8k+8; inputs are sampled at edge 32f+24 and
    // become visible from frame f+1. Blink phase = (consecutive adj cycles / 80) odd.
    int n, shown_min, shown_sec, pend_min, pend_sec, adj_run;

    always @(posedge clk or negedge rst_n) begin
        exp_t e;
        int   d, v;
        bit   blank;
        if (!rst_n) begin
            n = 0; shown_min = 0; shown_sec = 0; pend_min = 0; pend_sec = 0; adj_run = 0;
            exp_q.delete();
        end else begin
            n++;
            d = ((n - 1) / DIG) % 4;
            case (d)
                0:       v = shown_sec % 10;
                1:       v = shown_sec / 10;
                2:       v = shown_min % 10;
                default: v = shown_min / 10;
            endcase
            blank = disp.adj && (((adj_run / BLINK) % 2) == 1) && (disp.sel ? (d < 2) : (d >= 2));
            e.an = 4'hF;
            if (!blank) e.an[d] = 1'b0;
            e.seg = seg_tab[v];
            e.dp  = (d == 2) ? 1'b0 : 1'b1;
            exp_q.push_back(e);
            if (n % FRAME == 24) begin
                pend_min = int'(disp.min);
                pend_sec = int'(disp.sec);
            end
            if (n % FRAME == 0) begin
                shown_min = pend_min;
                shown_sec = pend_sec;
            end
            adj_run = disp.adj ? adj_run + 1 : 0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            checks++;
            if (disp.an !== 4'hF || disp.seg !== 7'h7F || disp.dp !== 1'b1) begin
                errors++;
                $display("FAIL reset_hold t=%0t got an=%b seg=%b dp=%b want an=1111 seg=1111111 dp=1",
                         $time, disp.an, disp.seg, disp.dp);
            end
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (disp.an !== e.an || disp.seg !== e.seg || disp.dp !== e.dp) begin
                errors++;
                $display("FAIL display_out t=%0t n=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                         $time, n, disp.an, disp.seg, disp.dp, e.an, e.seg, e.dp);
            end
        end
    end

    task automatic tick(input int c);
        repeat (c) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_now();
        checks++;
        if (disp.an !== 4'hF || disp.seg !== 7'h7F || disp.dp !== 1'b1) begin
            errors++;
            $display("FAIL async_reset got an=%b seg=%b dp=%b want an=1111 seg=1111111 dp=1",
                     disp.an, disp.seg, disp.dp);
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        check_reset_now();
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic wait_frame_pos(input int pos);
        for (int i = 0; i < 2 * FRAME && (n % FRAME) != pos; i++) tick(1);
        checks++;
        if ((n % FRAME) != pos) begin
            errors++;
            $display("FAIL wait_frame_pos got %0d want %0d", n % FRAME, pos);
        end
    endtask

    task automatic wait_blank_window();
        for (int i = 0; i < 3 * BLINK && ((adj_run / BLINK) % 2) != 1; i++) tick(1);
        checks++;
        if (((adj_run / BLINK) % 2) != 1) begin
            errors++;
            $display("FAIL wait_blank_window got run=%0d want odd phase", adj_run);
        end
    endtask

    initial begin
        rst_n    = 1'b1;
        disp.min = 6'd0;
        disp.sec = 6'd0;
        disp.adj = 1'b0;
        disp.sel = 1'b0;
        #2 rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;

        // Zero display, then async reset mid-run.
        tick(2 * FRAME + 5);
        pulse_reset();
        tick(2 * FRAME);

        // 20.15 held, then seconds change mid-frame while idx=1.
        disp.min = 6'd20;
        disp.sec = 6'd15;
        tick(3 * FRAME);
        wait_frame_pos(10);
        disp.sec = 6'd16;
        tick(3 * FRAME);

        // Minutes blink, then a sel change mid-blink, then adj drops in a blank window.
        disp.sec = 6'd30;
        disp.adj = 1'b1;
        disp.sel = 1'b0;
        tick(400);
        disp.sel = 1'b1;
        tick(200);
        wait_blank_window();
        tick(7);
        disp.adj = 1'b0;
        tick(100);

        // Out-of-range minutes shown as-is, reset during conversion.
        disp.min = 6'd63;
        disp.sec = 6'd59;
        tick(3 * FRAME);
        wait_frame_pos(27);
        pulse_reset();
        tick(3 * FRAME);

        // Randomized inputs.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(15, 0) == 0) disp.min = 6'($urandom_range(63, 0));
            if ($urandom_range(7, 0) == 0)  disp.sec = 6'($urandom_range(63, 0));
            if ($urandom_range(63, 0) == 0) disp.adj = ~disp.adj;
            if ($urandom_range(31, 0) == 0) disp.sel = ~disp.sel;
            tick(1);
        end
        disp.adj = 1'b0;
        tick(3 * FRAME);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
